// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO round-robin scheduler: read FSM encoding
// and width helpers for the word and lane-index buses.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        RD_WAIT  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_GAP   = 2'd2
    } rd_state_e;

    // Word width: one DATA_WIDTH slice per channel.
    function automatic int word_w(input int data_width, input int channel);
        return data_width * channel;
    endfunction

    // Lane-index width; never narrower than one bit.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_tag_fifo.sv
// Tag FIFO: records which lane produced each word in the shared data FIFO.
// Pushed on every data write, popped on every data read, so its head always
// lines up with the data FIFO head.
module tag_fifo #(
    parameter int DEPTH = 8,
    parameter int IDW   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [IDW-1:0] din_i,
    output logic [IDW-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry an extra wrap bit above the address bits.
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic [IDW-1:0] mem_q [DEPTH];

    // Advance a wrap-bit pointer; handles depths that are not a power of two.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            return {~p[AW], {AW{1'b0}}};
        end
        return p + (AW + 1)'(1);
    endfunction

    // Pointer update on push/pop; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop_i) begin
                rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

    assign head_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter and paced read scheduler for the shared
// multi-channel FIFO. Lanes compete for the single write port; reads are
// spaced so the FIFO's stale-data cycle after each read is never sampled.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNEL    = 3,
    parameter int DEPTH      = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQ-1:0]                             s_valid_i,
    input  logic [NUM_REQ*word_w(DATA_WIDTH,CHANNEL)-1:0]  s_data_i,
    output logic [NUM_REQ-1:0]                             s_ready_o,
    output logic                                           fifo_wr_req_o,
    output logic [word_w(DATA_WIDTH,CHANNEL)-1:0]          fifo_data_in_o,
    output logic                                           fifo_rd_req_o,
    input  logic [word_w(DATA_WIDTH,CHANNEL)-1:0]          fifo_data_out_i,
    input  logic                                           fifo_full_i,
    input  logic                                           fifo_empty_i,
    output logic                                           m_valid_o,
    output logic [word_w(DATA_WIDTH,CHANNEL)-1:0]          m_data_o,
    output logic [id_w(NUM_REQ)-1:0]                       m_id_o,
    input  logic                                           m_ready_i,
    output logic [$clog2(DEPTH):0]                         level_o
);

    localparam int W   = word_w(DATA_WIDTH, CHANNEL);
    localparam int IDW = id_w(NUM_REQ);
    localparam int LW  = $clog2(DEPTH) + 1;

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               wr;
    logic [W-1:0]       wdata;

    rd_state_e          state_q;
    logic               rd_req_q;
    logic               empty_q;
    logic               issue_ok;

    logic               m_valid_q;
    logic [W-1:0]       m_data_q;
    logic [IDW-1:0]     m_id_q;
    logic [IDW-1:0]     tag_head;

    logic [LW-1:0]      level_q, level_d;

    // One-hot grant to the first requester at or after ptr, wrapping.
    // Scanning offsets from highest to lowest lets the nearest one win.
    function automatic logic [NUM_REQ-1:0] rr_grant(
        input logic [NUM_REQ-1:0] req,
        input logic [IDW-1:0]     ptr
    );
        logic [NUM_REQ-1:0] g;
        int                 idx;
        g = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // Grant is withheld while the FIFO is full and while reset is held,
    // so nothing is accepted that the reset is about to discard.
    always_comb begin
        gnt = '0;
        if (!rst && !fifo_full_i) begin
            gnt = rr_grant(s_valid_i, rr_ptr_q);
        end
    end

    // Encode the grant and mux the winning lane's word onto the write port.
    always_comb begin
        gnt_idx = '0;
        wdata   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDW'(i);
                wdata   = s_data_i[i*W +: W];
            end
        end
    end

    assign wr = |gnt;

    // Next pointer: one past the winner, wrapping at NUM_REQ; holds if idle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (wr) begin
            rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Previous-cycle empty flag; a read needs two consecutive non-empty cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_q <= 1'b1;
        end else begin
            empty_q <= fifo_empty_i;
        end
    end

    // The output register is free if empty or being accepted this cycle.
    assign issue_ok = !fifo_empty_i && !empty_q && (!m_valid_q || m_ready_i);

    // Read scheduler: one-cycle read strobe, then a stale-data gap cycle.
    // The gap falls straight through to a new read when the wait condition
    // already holds, giving the one-word-per-two-cycles peak drain rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RD_WAIT;
            rd_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                RD_WAIT: begin
                    if (issue_ok) begin
                        state_q  <= RD_ISSUE;
                        rd_req_q <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    state_q  <= RD_GAP;
                    rd_req_q <= 1'b0;
                end
                RD_GAP: begin
                    if (issue_ok) begin
                        state_q  <= RD_ISSUE;
                        rd_req_q <= 1'b1;
                    end else begin
                        state_q  <= RD_WAIT;
                    end
                end
                default: begin
                    state_q  <= RD_WAIT;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Output register: load on a read, clear on accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
        end else if (rd_req_q) begin
            m_valid_q <= 1'b1;
            m_data_q  <= fifo_data_out_i;
            m_id_q    <= tag_head;
        end else if (m_valid_q && m_ready_i) begin
            m_valid_q <= 1'b0;
        end
    end

    // Occupancy: a simultaneous write and read leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (wr && !rd_req_q) begin
            level_d = level_q + LW'(1);
        end else if (!wr && rd_req_q) begin
            level_d = level_q - LW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (wr),
        .pop_i  (rd_req_q),
        .din_i  (gnt_idx),
        .head_o (tag_head)
    );

    assign s_ready_o      = gnt;
    assign fifo_wr_req_o  = wr;
    assign fifo_data_in_o = wdata;
    assign fifo_rd_req_o  = rd_req_q;
    assign m_valid_o      = m_valid_q;
    assign m_data_o       = m_data_q;
    assign m_id_o         = m_id_q;
    assign level_o        = level_q;

endmodule
